// File: rtl/int_div_seq.sv
// rtl/int_div_seq.sv - multi-cycle restoring integer divider, signed/unsigned, req/ready/ack handshake
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset; aborts any operation in flight
//   req        start request, sampled only while ready=1
//   is_signed  1 = two's-complement divide, 0 = unsigned; sampled with req
//   a, b       dividend and divisor; sampled with req
//   ready      high while idle and able to accept req
//   ack        one-cycle pulse; quotient/remainder valid while high
//   quotient   result, held until the next ack
//   remainder  result, held until the next ack
module int_div_seq #(
    parameter int bitwidth = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                is_signed,
    input  logic [bitwidth-1:0] a,
    input  logic [bitwidth-1:0] b,
    output logic                ready,
    output logic                ack,
    output logic [bitwidth-1:0] quotient,
    output logic [bitwidth-1:0] remainder
);

    localparam int cnt_w = $clog2(bitwidth + 1);
    localparam logic [bitwidth-1:0] most_neg = {1'b1, {(bitwidth-1){1'b0}}};
    localparam logic [bitwidth-1:0] all_ones = {bitwidth{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Operation context captured on the accept edge
    logic [bitwidth-1:0] a_hold;
    logic [bitwidth-1:0] dvs;        // divisor magnitude
    logic [bitwidth-1:0] dvd;        // dividend magnitude, becomes the quotient magnitude
    logic [bitwidth-1:0] part_rem;   // partial remainder, always < dvs between steps
    logic [cnt_w-1:0]    cnt;
    logic                neg_q;
    logic                neg_r;
    logic                div_zero;
    logic                overflow;

    // Input decode, only meaningful in IDLE
    logic                a_neg;
    logic                b_neg;
    logic [bitwidth-1:0] a_mag;
    logic [bitwidth-1:0] b_mag;
    logic                zero_b;
    logic                ovf_in;

    // One restoring step; the extra top bit of trial is the borrow
    logic [bitwidth:0]   shifted;
    logic [bitwidth:0]   trial;
    logic                q_bit;

    // Sign-corrected final results
    logic [bitwidth-1:0] q_final;
    logic [bitwidth-1:0] r_final;

    assign a_neg  = is_signed & a[bitwidth-1];
    assign b_neg  = is_signed & b[bitwidth-1];
    // Negating most_neg yields most_neg again, which read as unsigned is the
    // correct magnitude 2^(bitwidth-1).
    assign a_mag  = a_neg ? (~a) + bitwidth'(1) : a;
    assign b_mag  = b_neg ? (~b) + bitwidth'(1) : b;
    assign zero_b = (b == '0);
    assign ovf_in = is_signed & (a == most_neg) & (b == all_ones);

    assign shifted = {part_rem, dvd[bitwidth-1]};
    assign trial   = shifted - {1'b0, dvs};
    assign q_bit   = ~trial[bitwidth];

    assign q_final = neg_q ? (~dvd) + bitwidth'(1) : dvd;
    assign r_final = neg_r ? (~part_rem) + bitwidth'(1) : part_rem;

    assign ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    // Special cases skip the iteration entirely
                    state_next = (zero_b || ovf_in) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == cnt_w'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack       <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            a_hold    <= '0;
            dvs       <= '0;
            dvd       <= '0;
            part_rem  <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            ack <= (state == DONE);
            case (state)
                IDLE: begin
                    if (req) begin
                        a_hold   <= a;
                        div_zero <= zero_b;
                        overflow <= ovf_in;
                        dvd      <= a_mag;
                        dvs      <= b_mag;
                        part_rem <= '0;
                        cnt      <= cnt_w'(bitwidth);
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                    end
                end
                RUN: begin
                    // A restored value is below dvs, so dropping the top bit loses nothing
                    part_rem <= q_bit ? trial[bitwidth-1:0] : shifted[bitwidth-1:0];
                    dvd      <= {dvd[bitwidth-2:0], q_bit};
                    cnt      <= cnt - cnt_w'(1);
                end
                DONE: begin
                    if (div_zero) begin
                        quotient  <= all_ones;
                        remainder <= a_hold;
                    end else if (overflow) begin
                        quotient  <= a_hold;
                        remainder <= '0;
                    end else begin
                        quotient  <= q_final;
                        remainder <= r_final;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_div_seq.sv
// tb/tb_int_div_seq.sv - directed self-checking bench for int_div_seq (32-bit and 8-bit instances)
module tb_int_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        ready;
    logic        ack;
    logic [31:0] quotient;
    logic [31:0] remainder;

    logic        req8;
    logic        is_signed8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        ready8;
    logic        ack8;
    logic [7:0]  quotient8;
    logic [7:0]  remainder8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    int_div_seq #(.bitwidth(32)) dut (
        .clk(clk), .rst(rst), .req(req), .is_signed(is_signed), .a(a), .b(b),
        .ready(ready), .ack(ack), .quotient(quotient), .remainder(remainder)
    );

    int_div_seq #(.bitwidth(8)) dut8 (
        .clk(clk), .rst(rst), .req(req8), .is_signed(is_signed8), .a(a8), .b(b8),
        .ready(ready8), .ack(ack8), .quotient(quotient8), .remainder(remainder8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic op32(input string tag, input logic s, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eq, input logic [31:0] er, input int elat);
        int n;
        bit got;
        @(negedge clk);
        chk({tag, " ready_before"}, 32'(ready), 32'd1);
        is_signed = s; a = av; b = bv; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0; a = ~av; b = ~bv; is_signed = ~s;
        chk({tag, " ready_after"}, 32'(ready), 32'd0);
        got = 0; n = 0;
        while (!got && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (ack) got = 1;
        end
        chk({tag, " latency"}, 32'(n + 1), 32'(elat));
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
    endtask

    task automatic op8(input logic s, input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] eq, input logic [7:0] er, input int elat);
        int n;
        bit got;
        @(negedge clk);
        is_signed8 = s; a8 = av; b8 = bv; req8 = 1'b1;
        @(posedge clk);
        #1;
        req8 = 1'b0;
        got = 0; n = 0;
        while (!got && n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (ack8) got = 1;
        end
        chk($sformatf("w8 s=%0d a=%h b=%h latency", s, av, bv), 32'(n + 1), 32'(elat));
        chk($sformatf("w8 s=%0d a=%h b=%h quotient", s, av, bv), 32'(quotient8), 32'(eq));
        chk($sformatf("w8 s=%0d a=%h b=%h remainder", s, av, bv), 32'(remainder8), 32'(er));
    endtask

    // Reference for the 8-bit instance built on native SV integer division
    task automatic model8(input logic s, input logic [7:0] x, input logic [7:0] y,
                          output logic [7:0] q, output logic [7:0] r, output int lat);
        int sx;
        int sy;
        sx = int'($signed(x));
        sy = int'($signed(y));
        lat = 10;
        if (y == 8'd0) begin
            q = 8'hFF; r = x; lat = 2;
        end else if (!s) begin
            q = x / y; r = x % y;
        end else if (sx == -128 && sy == -1) begin
            q = 8'h80; r = 8'h00; lat = 2;
        end else begin
            q = 8'(sx / sy); r = 8'(sx % sy);
        end
    endtask

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } op_t;

    initial begin
        op_t ops[4];
        logic [7:0] vals[16];
        logic [7:0] mq;
        logic [7:0] mr;
        int mlat;
        int n;
        int strays;
        bit got;

        rst = 1'b1; req = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        req8 = 1'b0; is_signed8 = 1'b0; a8 = '0; b8 = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset ack", 32'(ack), 32'd0);
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", remainder, 32'd0);
        chk("reset ready8", 32'(ready8), 32'd1);
        chk("reset quotient8", 32'(quotient8), 32'd0);

        op32("u 123153/2424", 1'b0, 32'd123153, 32'd2424, 32'd50, 32'd1953, 34);
        op32("u 11/3", 1'b0, 32'd11, 32'd3, 32'd3, 32'd2, 34);
        op32("s -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
        op32("s 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 34);
        op32("s -7/-2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 34);
        op32("u fff9/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 34);
        op32("u 7/0", 1'b0, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, 2);
        op32("s 7/0", 1'b1, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, 2);
        op32("s ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 2);
        op32("u 8000/ffff", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 34);
        op32("s min/1", 1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 34);

        // Back-to-back with req held high; each op is presented in the previous ack cycle
        ops[0] = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34};
        ops[1] = '{1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 34};
        ops[2] = '{1'b1, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, 2};
        ops[3] = '{1'b1, 32'hFFFF_FFF7, 32'd4, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 34};
        @(negedge clk);
        req = 1'b1; is_signed = ops[0].s; a = ops[0].a; b = ops[0].b;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("b2b%0d ready_after", i), 32'(ready), 32'd0);
            got = 0; n = 0;
            while (!got && n < 60) begin
                @(posedge clk);
                #1;
                n++;
                if (ack) got = 1;
            end
            chk($sformatf("b2b%0d latency", i), 32'(n + 1), 32'(ops[i].lat));
            chk($sformatf("b2b%0d quotient", i), quotient, ops[i].q);
            chk($sformatf("b2b%0d remainder", i), remainder, ops[i].r);
            chk($sformatf("b2b%0d ready_in_ack", i), 32'(ready), 32'd1);
            if (i < 3) begin
                is_signed = ops[i+1].s; a = ops[i+1].a; b = ops[i+1].b;
            end else begin
                req = 1'b0;
            end
        end

        // A req pulse during RUN must be dropped, not queued
        @(negedge clk);
        req = 1'b1; is_signed = 1'b0; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        #1;
        req = 1'b0;
        got = 0; n = 0;
        while (!got && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (ack) got = 1;
            if (n == 5) begin
                req = 1'b1; is_signed = 1'b1; a = 32'd50; b = 32'd5;
            end
            if (n == 6) req = 1'b0;
        end
        chk("busy latency", 32'(n + 1), 32'd34);
        chk("busy quotient", quotient, 32'd333);
        chk("busy remainder", remainder, 32'd1);
        strays = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ack) strays++;
        end
        chk("busy stray acks", 32'(strays), 32'd0);

        // Reset in the middle of RUN
        @(negedge clk);
        req = 1'b1; is_signed = 1'b0; a = 32'd123153; b = 32'd2424;
        @(posedge clk);
        #1;
        req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst ready", 32'(ready), 32'd1);
        chk("midrst ack", 32'(ack), 32'd0);
        chk("midrst quotient", quotient, 32'd0);
        chk("midrst remainder", remainder, 32'd0);
        strays = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ack) strays++;
        end
        chk("midrst stray acks", 32'(strays), 32'd0);
        op32("post-rst 7/3", 1'b0, 32'd7, 32'd3, 32'd2, 32'd1, 34);

        // 8-bit cross product of boundary and mid-range operands, both modes
        vals = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h08, 8'h0D, 8'h55,
                 8'h64, 8'h7F, 8'h80, 8'h81, 8'hAA, 8'hC8, 8'hFE, 8'hFF};
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    model8(s[0], vals[i], vals[j], mq, mr, mlat);
                    op8(s[0], vals[i], vals[j], mq, mr, mlat);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
